// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch/timer counter chain.
// Holds radix field layout, default mm:ss radices and small elaboration-time helpers.
package stopwatch_pkg;

  localparam int BASE_FIELD_BITS = 8;
  localparam logic [31:0] DEFAULT_BASE_VEC = 32'h06_0A_06_0A;

  // Smallest width (at least 1) whose range covers 0..value-1.
  function automatic int presc_width(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // Out-of-range loaded digits saturate at the digit's largest legal value.
  function automatic int clamp_digit(input int value, input int base);
    return (value >= base) ? base - 1 : value;
  endfunction

endpackage

// File: rtl/radix_digit.sv
// One digit of the mixed-radix chain: up/down with wrap, clamped load, sync clear.
// Steps only when the parent asserts step; the ripple decision lives in the parent.
module radix_digit
  import stopwatch_pkg::*;
#(
  parameter int BASE       = 10,
  parameter int DIGIT_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [DIGIT_BITS-1:0] load_value,
  input  logic                  clear,
  output logic [DIGIT_BITS-1:0] value,
  output logic                  at_max,
  output logic                  at_zero
);

  localparam logic [DIGIT_BITS-1:0] MAX_V = DIGIT_BITS'(BASE - 1);

  generate
    if (BASE < 2 || BASE > (1 << DIGIT_BITS)) begin : g_bad_base
      $error("radix_digit: BASE %0d does not fit DIGIT_BITS %0d", BASE, DIGIT_BITS);
    end
  endgenerate

  assign at_max  = (value == MAX_V);
  assign at_zero = (value == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= DIGIT_BITS'(clamp_digit(int'(load_value), BASE));
    end else if (step) begin
      if (up_down) value <= at_max ? '0 : value + 1'b1;
      else         value <= at_zero ? MAX_V : value - 1'b1;
    end
  end

endmodule

// File: rtl/mixed_radix_timer.sv
// Prescaled, cascaded mixed-radix up/down counter with load, clear and wrap/stop modes.
// Owns the prescaler, the ripple-enable chain and the registered tick/carry pulses.
module mixed_radix_timer
  import stopwatch_pkg::*;
#(
  parameter int          NUM_DIGITS = 4,
  parameter int          DIGIT_BITS = 4,
  parameter logic [31:0] BASE_VEC   = DEFAULT_BASE_VEC,
  parameter int          CLK_HZ     = 100_000_000,
  parameter int          TICK_HZ    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             up_down,
  input  logic                             mode_stop,
  input  logic                             clear,
  input  logic                             load,
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0] load_value,
  output logic [NUM_DIGITS*DIGIT_BITS-1:0] count,
  output logic                             tick,
  output logic                             carry,
  output logic                             at_terminal
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PW    = presc_width(DIV);
  localparam int BASE0 = int'(BASE_VEC[BASE_FIELD_BITS-1:0]);

  generate
    if (DIV < 1 || DIV * TICK_HZ != CLK_HZ) begin : g_bad_div
      $error("mixed_radix_timer: CLK_HZ/TICK_HZ must be an integer >= 1");
    end
  endgenerate

  logic [PW-1:0]         presc;
  logic                  strobe;
  logic                  step_en;
  logic                  near_term;
  logic                  upper_max;
  logic                  upper_zero;
  logic                  carry_next;
  logic [NUM_DIGITS-1:0] at_max;
  logic [NUM_DIGITS-1:0] at_zero;
  logic [NUM_DIGITS-1:0] dig_step;

  assign at_terminal = up_down ? (&at_max) : (&at_zero);
  assign strobe      = enable && (presc == PW'(DIV - 1));
  // In stop mode a strobe at the terminal value is swallowed entirely.
  assign step_en     = strobe && !clear && !load && !(mode_stop && at_terminal);

  always_comb begin
    dig_step    = '0;
    upper_max   = 1'b1;
    upper_zero  = 1'b1;
    dig_step[0] = step_en;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      dig_step[i] = dig_step[i-1] && (up_down ? at_max[i-1] : at_zero[i-1]);
      upper_max   = upper_max && at_max[i];
      upper_zero  = upper_zero && at_zero[i];
    end
  end

  // One step short of terminal: only digit 0 moves, so compare it alone.
  assign near_term = up_down
                     ? (upper_max  && count[DIGIT_BITS-1:0] == DIGIT_BITS'(BASE0 - 2))
                     : (upper_zero && count[DIGIT_BITS-1:0] == DIGIT_BITS'(1));
  assign carry_next = step_en && (mode_stop ? near_term : at_terminal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else begin
      tick  <= strobe;
      carry <= carry_next;
      if (clear || load)  presc <= '0;
      else if (enable)    presc <= strobe ? '0 : presc + 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      radix_digit #(
        .BASE       (int'(BASE_VEC[g*BASE_FIELD_BITS +: BASE_FIELD_BITS])),
        .DIGIT_BITS (DIGIT_BITS)
      ) u_digit (
        .clk        (clk),
        .rst        (rst),
        .step       (dig_step[g]),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value[g*DIGIT_BITS +: DIGIT_BITS]),
        .clear      (clear),
        .value      (count[g*DIGIT_BITS +: DIGIT_BITS]),
        .at_max     (at_max[g]),
        .at_zero    (at_zero[g])
      );
    end
  endgenerate

endmodule
